// File: rtl/rename_map_unit_pkg.sv
// Shared types and sizing for the register-rename slice: index widths,
// free-list geometry and the bundled rename result.
package rename_map_unit_pkg;
  localparam int ARCH_REGS  = 32;
  localparam int PHYS_REGS  = 64;
  localparam int FREE_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int FL_PTR_W   = 6;

  typedef logic [5:0]          phys_idx_t;
  typedef logic [4:0]          arch_idx_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;

  typedef struct packed {
    phys_idx_t rs1_phys;
    phys_idx_t rs2_phys;
    phys_idx_t dest_phys_new;
    phys_idx_t dest_phys_old;
  } rename_out_t;
endpackage

// File: rtl/rename_map_unit_free_list.sv
// Circular free list of physical registers. Slots between retire_head and
// alloc_head still hold in-flight allocations, so restore reclaims them in order.
module rename_map_unit_free_list
  import rename_map_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      pop_i,
  input  logic      push_i,
  input  phys_idx_t push_data_i,
  input  logic      retire_adv_i,
  input  logic      restore_i,
  output phys_idx_t head_data_o,
  output fl_ptr_t   count_o,
  output fl_ptr_t   alloc_head_o,
  output fl_ptr_t   retire_head_o
);
  phys_idx_t mem_q [FREE_DEPTH];
  fl_ptr_t   alloc_head_q, alloc_head_d;
  fl_ptr_t   retire_head_q, retire_head_d;
  fl_ptr_t   tail_q, tail_d;

  always_comb begin
    retire_head_d = retire_head_q + fl_ptr_t'(retire_adv_i);
    tail_d        = tail_q + fl_ptr_t'(push_i);
    alloc_head_d  = alloc_head_q;
    // Restore targets the post-commit retire pointer so a same-cycle commit is kept.
    if (restore_i) begin
      alloc_head_d = retire_head_d;
    end else if (pop_i) begin
      alloc_head_d = alloc_head_q + fl_ptr_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FREE_DEPTH; i++) begin
        mem_q[i] <= phys_idx_t'(FREE_DEPTH + i);
      end
      alloc_head_q  <= '0;
      retire_head_q <= '0;
      tail_q        <= fl_ptr_t'(FREE_DEPTH);
    end else begin
      if (push_i) begin
        mem_q[tail_q[FL_PTR_W-2:0]] <= push_data_i;
      end
      alloc_head_q  <= alloc_head_d;
      retire_head_q <= retire_head_d;
      tail_q        <= tail_d;
    end
  end

  assign head_data_o   = mem_q[alloc_head_q[FL_PTR_W-2:0]];
  assign count_o       = tail_q - alloc_head_q;
  assign alloc_head_o  = alloc_head_q;
  assign retire_head_o = retire_head_q;
endmodule

// File: rtl/rename_map_unit.sv
// Rename stage: speculative RAT, retirement RAT and free-list control.
// Lookups are combinational; flush rebuilds the RAT from the retirement copy.
module rename_map_unit
  import rename_map_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rename_valid,
  input  logic       stall,
  input  logic [4:0] rs1_arch,
  input  logic [4:0] rs2_arch,
  input  logic [4:0] rd_arch,
  input  logic       rd_we,
  output logic       rename_ready,
  output logic [5:0] rs1_phys,
  output logic [5:0] rs2_phys,
  output logic [5:0] dest_phys_new,
  output logic [5:0] dest_phys_old,
  input  logic       commit_valid,
  input  logic       commit_rd_we,
  input  logic [4:0] commit_arch,
  input  logic [5:0] commit_phys_new,
  input  logic [5:0] commit_phys_old,
  input  logic       flush,
  output logic [5:0] free_count
);
  phys_idx_t   rat_q  [ARCH_REGS];
  phys_idx_t   rat_d  [ARCH_REGS];
  phys_idx_t   rrat_q [ARCH_REGS];
  phys_idx_t   rrat_d [ARCH_REGS];
  phys_idx_t   head_data;
  fl_ptr_t     fl_count;
  fl_ptr_t     alloc_head;
  fl_ptr_t     retire_head;
  rename_out_t ren;
  logic        alloc_need;
  logic        fire;
  logic        commit_we;

  assign alloc_need   = rd_we && (rd_arch != '0);
  assign rename_ready = !alloc_need || (fl_count != '0);
  assign fire         = rename_valid && rename_ready && !stall && !flush;
  assign commit_we    = commit_valid && commit_rd_we;

  rename_map_unit_free_list u_free_list (
    .clk           (clk),
    .rst           (rst),
    .pop_i         (fire && alloc_need),
    .push_i        (commit_we),
    .push_data_i   (commit_phys_old),
    .retire_adv_i  (commit_we),
    .restore_i     (flush),
    .head_data_o   (head_data),
    .count_o       (fl_count),
    .alloc_head_o  (alloc_head),
    .retire_head_o (retire_head)
  );

  always_comb begin
    ren.rs1_phys      = rat_q[rs1_arch];
    ren.rs2_phys      = rat_q[rs2_arch];
    ren.dest_phys_new = alloc_need ? head_data : '0;
    ren.dest_phys_old = alloc_need ? rat_q[rd_arch] : '0;
  end

  always_comb begin
    rrat_d = rrat_q;
    if (commit_we) begin
      rrat_d[commit_arch] = commit_phys_new;
    end
    rat_d = rat_q;
    if (flush) begin
      rat_d = rrat_d;
    end else if (fire && alloc_need) begin
      rat_d[rd_arch] = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i]  <= phys_idx_t'(i);
        rrat_q[i] <= phys_idx_t'(i);
      end
    end else begin
      rat_q  <= rat_d;
      rrat_q <= rrat_d;
    end
  end

  assign rs1_phys      = ren.rs1_phys;
  assign rs2_phys      = ren.rs2_phys;
  assign dest_phys_new = ren.dest_phys_new;
  assign dest_phys_old = ren.dest_phys_old;
  assign free_count    = fl_count;

  a_no_alloc_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(fire && alloc_need && fl_count == '0));
  a_no_commit_when_idle: assert property (@(posedge clk) disable iff (rst)
    commit_we |-> (retire_head != alloc_head));
  a_commit_old_nonzero: assert property (@(posedge clk) disable iff (rst)
    commit_we |-> (commit_phys_old != '0));
endmodule

// File: tb/tb_rename_map_unit.sv
// Bench for rename_map_unit: directed scenarios plus randomized traffic checked
// against a queue-based model of the maps, free registers and in-flight renames.
module tb_rename_map_unit;
  logic       clk;
  logic       rst;
  logic       rename_valid, stall, rd_we;
  logic [4:0] rs1_arch, rs2_arch, rd_arch;
  logic       rename_ready;
  logic [5:0] rs1_phys, rs2_phys, dest_phys_new, dest_phys_old;
  logic       commit_valid, commit_rd_we;
  logic [4:0] commit_arch;
  logic [5:0] commit_phys_new, commit_phys_old;
  logic       flush;
  logic [5:0] free_count;

  rename_map_unit dut (
    .clk(clk), .rst(rst), .rename_valid(rename_valid), .stall(stall),
    .rs1_arch(rs1_arch), .rs2_arch(rs2_arch), .rd_arch(rd_arch), .rd_we(rd_we),
    .rename_ready(rename_ready), .rs1_phys(rs1_phys), .rs2_phys(rs2_phys),
    .dest_phys_new(dest_phys_new), .dest_phys_old(dest_phys_old),
    .commit_valid(commit_valid), .commit_rd_we(commit_rd_we),
    .commit_arch(commit_arch), .commit_phys_new(commit_phys_new),
    .commit_phys_old(commit_phys_old), .flush(flush), .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int arch;
    int newp;
    int oldp;
  } ent_t;

  int   rat_m [32];
  int   rrat_m[32];
  int   flq[$];
  ent_t infl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      rat_m[i]  = i;
      rrat_m[i] = i;
    end
    flq.delete();
    for (int i = 0; i < 32; i++) flq.push_back(32 + i);
    infl.delete();
  endfunction

  task automatic set_in(input bit rv, input bit st, input int r1, input int r2,
                        input int rd, input bit we, input bit cv, input bit cwe,
                        input bit fl);
    if (cwe && infl.size() == 0) cwe = 1'b0;
    rename_valid = rv;
    stall        = st;
    rs1_arch     = 5'(r1);
    rs2_arch     = 5'(r2);
    rd_arch      = 5'(rd);
    rd_we        = we;
    commit_valid = cv;
    commit_rd_we = cwe;
    flush        = fl;
    if (cwe) begin
      commit_arch     = 5'(infl[0].arch);
      commit_phys_new = 6'(infl[0].newp);
      commit_phys_old = 6'(infl[0].oldp);
    end else begin
      commit_arch     = 5'(rd);
      commit_phys_new = 6'd1;
      commit_phys_old = 6'd1;
    end
  endtask

  // Advance one clock and apply the same transaction to the model.
  task automatic adv();
    bit   need, ready, fire;
    ent_t e;
    int   p;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      need  = rd_we && (rd_arch != 0);
      ready = !need || (flq.size() != 0);
      fire  = rename_valid && ready && !stall && !flush;
      if (commit_valid && commit_rd_we) begin
        e = infl.pop_front();
        flq.push_back(e.oldp);
        rrat_m[e.arch] = e.newp;
      end
      if (fire && need) begin
        p      = flq.pop_front();
        e.arch = int'(rd_arch);
        e.newp = p;
        e.oldp = rat_m[rd_arch];
        infl.push_back(e);
        rat_m[rd_arch] = p;
      end
      if (flush) begin
        for (int i = infl.size() - 1; i >= 0; i--) flq.push_front(infl[i].newp);
        infl.delete();
        for (int i = 0; i < 32; i++) rat_m[i] = rrat_m[i];
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_in(0, 0, 17, 0, 5, 1, 0, 0, 0);
    #1;
    n_tests++; if (free_count !== 6'd32) begin n_fail++; $display("FAIL reset_free_count got=%0d exp=32", free_count); end
    n_tests++; if (rename_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0b exp=1", rename_ready); end
    n_tests++; if (rs1_phys !== 6'd17) begin n_fail++; $display("FAIL reset_rat17 got=%0d exp=17", rs1_phys); end
    n_tests++; if (rs2_phys !== 6'd0) begin n_fail++; $display("FAIL reset_rat0 got=%0d exp=0", rs2_phys); end
  endtask

  task automatic test_basic_alloc();
    set_in(1, 0, 0, 0, 5, 1, 0, 0, 0);
    #1;
    n_tests++; if (dest_phys_new !== 6'd32) begin n_fail++; $display("FAIL x5_new got=%0d exp=32", dest_phys_new); end
    n_tests++; if (dest_phys_old !== 6'd5) begin n_fail++; $display("FAIL x5_old got=%0d exp=5", dest_phys_old); end
    adv();
    set_in(0, 0, 5, 0, 0, 0, 0, 0, 0);
    #1;
    n_tests++; if (rs1_phys !== 6'd32) begin n_fail++; $display("FAIL x5_lookup got=%0d exp=32", rs1_phys); end
  endtask

  task automatic test_no_alloc();
    set_in(1, 0, 0, 0, 0, 1, 0, 0, 0);
    #1;
    n_tests++; if ({dest_phys_new, dest_phys_old} !== 12'd0) begin n_fail++; $display("FAIL x0_dest got=%0d/%0d exp=0/0", dest_phys_new, dest_phys_old); end
    adv();
    set_in(1, 0, 0, 0, 7, 0, 0, 0, 0);
    #1;
    n_tests++; if ({dest_phys_new, dest_phys_old} !== 12'd0) begin n_fail++; $display("FAIL nowe_dest got=%0d/%0d exp=0/0", dest_phys_new, dest_phys_old); end
    adv();
    set_in(1, 0, 0, 0, 9, 1, 0, 0, 0);
    #1;
    n_tests++; if (dest_phys_new !== 6'd33) begin n_fail++; $display("FAIL head_kept got=%0d exp=33", dest_phys_new); end
    n_tests++; if (free_count !== 6'd31) begin n_fail++; $display("FAIL head_kept_count got=%0d exp=31", free_count); end
    adv();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      set_in(1, 0, 0, 0, (i == 0) ? 3 : (i % 30) + 1, 1, 0, 0, 0);
      adv();
    end
    set_in(1, 0, 0, 0, 9, 1, 0, 0, 0);
    #1;
    n_tests++; if (rename_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%0b exp=0", rename_ready); end
    n_tests++; if (free_count !== 6'd0) begin n_fail++; $display("FAIL full_count got=%0d exp=0", free_count); end
    set_in(1, 0, 0, 0, 9, 1, 1, 1, 0);
    #1;
    n_tests++; if (rename_ready !== 1'b0) begin n_fail++; $display("FAIL no_bypass_ready got=%0b exp=0", rename_ready); end
    adv();
    set_in(1, 0, 0, 0, 9, 1, 0, 0, 0);
    #1;
    n_tests++; if (rename_ready !== 1'b1) begin n_fail++; $display("FAIL refill_ready got=%0b exp=1", rename_ready); end
    n_tests++; if (dest_phys_new !== 6'd3) begin n_fail++; $display("FAIL refill_new got=%0d exp=3", dest_phys_new); end
    adv();
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1, 0, 0, 0, 1, 1, 0, 0, 0); adv();
    set_in(1, 0, 0, 0, 2, 1, 0, 0, 0); adv();
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); adv();
    set_in(1, 0, 0, 0, 9, 1, 0, 0, 1); adv();
    set_in(0, 0, 1, 2, 6, 1, 0, 0, 0);
    #1;
    n_tests++; if (rs1_phys !== 6'd32) begin n_fail++; $display("FAIL flush_rat1 got=%0d exp=32", rs1_phys); end
    n_tests++; if (rs2_phys !== 6'd2) begin n_fail++; $display("FAIL flush_rat2 got=%0d exp=2", rs2_phys); end
    n_tests++; if (free_count !== 6'(flq.size())) begin n_fail++; $display("FAIL flush_count got=%0d exp=%0d", free_count, flq.size()); end
    n_tests++; if (dest_phys_new !== 6'd33) begin n_fail++; $display("FAIL flush_reclaim got=%0d exp=33", dest_phys_new); end
    set_in(0, 0, 9, 0, 0, 0, 0, 0, 0);
    #1;
    n_tests++; if (rs1_phys !== 6'd9) begin n_fail++; $display("FAIL flush_drop got=%0d exp=9", rs1_phys); end
  endtask

  task automatic test_stall();
    do_reset();
    set_in(1, 0, 0, 0, 8, 1, 0, 0, 0); adv();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1, 8, 0, 8, 1, k == 1, k == 1, 0);
      #1;
      n_tests++; if (dest_phys_new !== 6'd33) begin n_fail++; $display("FAIL stall_head got=%0d exp=33", dest_phys_new); end
      n_tests++; if (rs1_phys !== 6'd32) begin n_fail++; $display("FAIL stall_rat got=%0d exp=32", rs1_phys); end
      adv();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_tests++; if (free_count !== 6'd32) begin n_fail++; $display("FAIL stall_commit_count got=%0d exp=32", free_count); end
  endtask

  task automatic test_flush_commit();
    do_reset();
    for (int i = 0; i < 8; i++) begin set_in(1, 0, 0, 0, 10 + i, 1, 0, 0, 0); adv(); end
    for (int i = 0; i < 8; i++) begin set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); adv(); end
    set_in(1, 0, 0, 0, 4, 1, 0, 0, 0);
    #1;
    n_tests++; if (dest_phys_new !== 6'd40) begin n_fail++; $display("FAIL fc_alloc got=%0d exp=40", dest_phys_new); end
    adv();
    set_in(1, 0, 0, 0, 6, 1, 1, 1, 1); adv();
    set_in(0, 0, 4, 6, 0, 0, 0, 0, 0);
    #1;
    n_tests++; if (rs1_phys !== 6'd40) begin n_fail++; $display("FAIL fc_rat4 got=%0d exp=40", rs1_phys); end
    n_tests++; if (rs2_phys !== 6'd6) begin n_fail++; $display("FAIL fc_rat6 got=%0d exp=6", rs2_phys); end
    n_tests++; if (free_count !== 6'd32) begin n_fail++; $display("FAIL fc_count got=%0d exp=32", free_count); end
  endtask

  task automatic test_random();
    int  r1, r2, rd;
    bit  we, need;
    for (int c = 0; c < 600; c++) begin
      r1 = $urandom_range(31, 0);
      r2 = $urandom_range(31, 0);
      rd = $urandom_range(31, 0);
      we = ($urandom % 4) != 0;
      set_in(($urandom % 8) != 0, ($urandom % 8) == 0, r1, r2, rd, we,
             ($urandom % 3) == 0, ($urandom % 5) != 0, ($urandom % 25) == 0);
      #1;
      need = we && rd != 0;
      n_tests++; if (rs1_phys !== 6'(rat_m[r1])) begin n_fail++; $display("FAIL rnd_rs1 c=%0d got=%0d exp=%0d", c, rs1_phys, rat_m[r1]); end
      n_tests++; if (rs2_phys !== 6'(rat_m[r2])) begin n_fail++; $display("FAIL rnd_rs2 c=%0d got=%0d exp=%0d", c, rs2_phys, rat_m[r2]); end
      n_tests++; if (free_count !== 6'(flq.size())) begin n_fail++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, free_count, flq.size()); end
      n_tests++; if (rename_ready !== (!need || flq.size() != 0)) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%0b", c, rename_ready); end
      n_tests++; if (dest_phys_old !== (need ? 6'(rat_m[rd]) : 6'd0)) begin n_fail++; $display("FAIL rnd_old c=%0d got=%0d", c, dest_phys_old); end
      if (!need) begin
        n_tests++; if (dest_phys_new !== 6'd0) begin n_fail++; $display("FAIL rnd_new_none c=%0d got=%0d exp=0", c, dest_phys_new); end
      end else if (flq.size() != 0) begin
        n_tests++; if (dest_phys_new !== 6'(flq[0])) begin n_fail++; $display("FAIL rnd_new c=%0d got=%0d exp=%0d", c, dest_phys_new, flq[0]); end
      end
      adv();
    end
  endtask

  task automatic test_reset_midop();
    rst = 1'b1;
    set_in(1, 0, 0, 0, 5, 1, 1, 1, 1);
    adv();
    rst = 1'b0;
    set_in(1, 0, 5, 31, 5, 1, 0, 0, 0);
    #1;
    n_tests++; if (free_count !== 6'd32) begin n_fail++; $display("FAIL midrst_count got=%0d exp=32", free_count); end
    n_tests++; if (rs1_phys !== 6'd5) begin n_fail++; $display("FAIL midrst_rat5 got=%0d exp=5", rs1_phys); end
    n_tests++; if (rs2_phys !== 6'd31) begin n_fail++; $display("FAIL midrst_rat31 got=%0d exp=31", rs2_phys); end
    n_tests++; if (dest_phys_new !== 6'd32) begin n_fail++; $display("FAIL midrst_new got=%0d exp=32", dest_phys_new); end
    adv();
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic_alloc();
    test_no_alloc();
    test_full();
    test_flush();
    test_stall();
    test_flush_commit();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
